// File: rtl/psram_spi_ctrl.sv
// Plain-SPI controller for the 64 Mbit on-board PSRAM: runs the power-up reset
// sequence (0x66, 0x99), then turns single-word requests into 64-bit frames.
module psram_spi_ctrl #(
  parameter int CLK_DIV     = 1,
  parameter int INIT_CYCLES = 4050,
  parameter int CE_GAP      = 2
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RSTn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [22:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        init_done,
  output logic        psram_cen,
  output logic        psram_sclk,
  output logic [3:0]  psram_sio_o,
  output logic [3:0]  psram_sio_oe,
  input  logic [3:0]  psram_sio_i
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CE_GAP - 1);
  localparam logic [6:0]        CMD_LAST  = 7'd7;
  localparam logic [6:0]        DATA_LAST = 7'd63;

  typedef enum logic [2:0] {
    INIT_WAIT,
    RSTEN,
    GAP,
    RST,
    IDLE,
    XFER
  } state_t;

  state_t            state;
  logic [INIT_W-1:0] init_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [6:0]        bit_cnt;
  logic [6:0]        bit_last;
  logic [63:0]       tx_shift;
  logic [31:0]       rx_shift;
  logic              mosi;
  logic              xfer_we;
  logic              gap_to_rst;

  logic              start_frame;
  logic [63:0]       start_bits;
  logic [6:0]        start_last;
  logic [31:0]       rx_le;
  logic              sio_unused;

  // SIO2/SIO3 are WP#/HOLD# and stay driven high; SIO1 is only ever an input.
  assign psram_sio_oe = 4'b1101;
  assign psram_sio_o  = {2'b11, 1'b0, mosi};
  assign sio_unused   = ^{psram_sio_i[3:2], psram_sio_i[0]};

  // Bytes arrive MSB-first in address order; the first byte belongs in [7:0].
  assign rx_le = {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};

  always_comb begin
    start_frame = 1'b0;
    start_bits  = '0;
    start_last  = CMD_LAST;
    case (state)
      INIT_WAIT: begin
        start_frame = (init_cnt == INIT_LAST);
        start_bits  = {8'h66, 56'h0};
      end
      GAP: begin
        start_frame = (gap_cnt == GAP_LAST) && gap_to_rst;
        start_bits  = {8'h99, 56'h0};
      end
      IDLE: begin
        start_frame = req_valid && req_ready;
        start_last  = DATA_LAST;
        start_bits  = req_we ?
                      {8'h02, 1'b0, req_addr, req_wdata[7:0], req_wdata[15:8],
                       req_wdata[23:16], req_wdata[31:24]} :
                      {8'h03, 1'b0, req_addr, 32'h0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RSTn) begin
      state      <= INIT_WAIT;
      init_cnt   <= '0;
      gap_cnt    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      bit_last   <= CMD_LAST;
      tx_shift   <= '0;
      rx_shift   <= '0;
      mosi       <= 1'b0;
      xfer_we    <= 1'b0;
      gap_to_rst <= 1'b0;
      psram_cen  <= 1'b1;
      psram_sclk <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      init_done  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        INIT_WAIT: begin
          if (start_frame) state <= RSTEN;
          else             init_cnt <= init_cnt + 1'b1;
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (gap_to_rst) begin
            state <= RST;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (start_frame) begin
            state     <= XFER;
            req_ready <= 1'b0;
            xfer_we   <= req_we;
          end
        end
        RSTEN, RST, XFER: begin
          // Each bit is CLK_DIV cycles low then CLK_DIV cycles high; MISO is
          // captured on the edge that raises SCLK, MOSI moves when it falls.
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!psram_sclk) begin
              psram_sclk <= 1'b1;
              rx_shift   <= {rx_shift[30:0], psram_sio_i[1]};
            end else if (bit_cnt == bit_last) begin
              psram_cen  <= 1'b1;
              psram_sclk <= 1'b0;
              mosi       <= 1'b0;
              gap_cnt    <= '0;
              gap_to_rst <= (state == RSTEN);
              state      <= GAP;
              if (state == XFER) begin
                rsp_valid <= 1'b1;
                if (!xfer_we) rsp_rdata <= rx_le;
              end
            end else begin
              psram_sclk <= 1'b0;
              bit_cnt    <= bit_cnt + 1'b1;
              mosi       <= tx_shift[63];
              tx_shift   <= {tx_shift[62:0], 1'b0};
            end
          end
        end
        default: state <= INIT_WAIT;
      endcase

      if (start_frame) begin
        psram_cen  <= 1'b0;
        psram_sclk <= 1'b0;
        mosi       <= start_bits[63];
        tx_shift   <= {start_bits[62:0], 1'b0};
        bit_cnt    <= '0;
        div_cnt    <= '0;
        bit_last   <= start_last;
      end
    end
  end

endmodule

// File: tb/tb_psram_spi_ctrl.sv
// Scoreboard bench for psram_spi_ctrl: two instances (CLK_DIV 1 and 2), each
// talking to a behavioural SPI PSRAM with its own memory and a reference memory.
module tb_psram_spi_ctrl;

  localparam int INIT_CYCLES = 20;
  localparam int CE_GAP      = 2;
  localparam int N_RANDOM    = 14;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          cycle;
  } rsp_t;

  typedef struct {
    int          len;
    logic [63:0] bits;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests      = 0;
  int fails      = 0;
  int lanes_done = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // The PSRAM wraps bursts inside its 1 KB page.
  function automatic logic [22:0] wrap_addr(input logic [22:0] base, input int k);
    logic [9:0] off;
    off = base[9:0] + 10'(k);
    return {base[22:10], off};
  endfunction

  function automatic logic [7:0] fresh_byte(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int DIV = g + 1;

    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [22:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, init_done, cen, sclk;
    logic [31:0] rsp_rdata;
    logic [3:0]  sio_o, sio_oe, sio_i;
    logic        miso = 1'b0;

    assign sio_i = {2'b00, miso, 1'b0};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    psram_spi_ctrl #(
      .CLK_DIV    (DIV),
      .INIT_CYCLES(INIT_CYCLES),
      .CE_GAP     (CE_GAP)
    ) dut (
      .SYS_CLK     (clk),
      .SYS_RSTn    (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .init_done   (init_done),
      .psram_cen   (cen),
      .psram_sclk  (sclk),
      .psram_sio_o (sio_o),
      .psram_sio_oe(sio_oe),
      .psram_sio_i (sio_i)
    );

    rsp_t        rsp_q[$];
    frame_t      frame_q[$];
    logic [7:0]  ref_mem   [logic [22:0]];
    logic [7:0]  psram_mem [logic [22:0]];
    logic [31:0] last_read = '0;
    int          last_end  = 0;

    function automatic logic [7:0] ref_byte(input logic [22:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fresh_byte(a);
    endfunction

    function automatic logic [7:0] psram_byte(input logic [22:0] a);
      return psram_mem.exists(a) ? psram_mem[a] : fresh_byte(a);
    endfunction

    // PSRAM device model: shifts MOSI in on rising SCLK, answers reads on
    // falling SCLK and scrambles MISO while SCLK is high.
    logic [63:0] cap       = '0;
    int          cap_cnt   = 0;
    bit          in_frame  = 1'b0;
    bit          aborted   = 1'b0;
    bit          rd_active = 1'b0;
    logic [22:0] rd_addr   = '0;

    always @(negedge rst_n) aborted = 1'b1;

    always @(negedge cen) begin
      cap       = '0;
      cap_cnt   = 0;
      in_frame  = 1'b1;
      aborted   = 1'b0;
      rd_active = 1'b0;
    end

    always @(posedge sclk) begin
      if (cen === 1'b0) begin
        cap = {cap[62:0], sio_o[0]};
        cap_cnt++;
        if (cap_cnt == 32) begin
          rd_addr   = cap[22:0];
          rd_active = (cap[31:24] == 8'h03);
        end
        miso <= 1'($urandom);
      end
    end

    always @(negedge sclk) begin : miso_drive
      int         j;
      logic [7:0] b;
      if (cen === 1'b0 && rd_active && cap_cnt >= 32 && cap_cnt < 64) begin
        j = cap_cnt - 32;
        b = psram_byte(wrap_addr(rd_addr, j / 8));
        miso <= b[7 - (j % 8)];
      end
    end

    always @(posedge cen) begin : frame_end
      frame_t f;
      if (in_frame) begin
        in_frame = 1'b0;
        if (!aborted) begin
          if (frame_q.size() == 0) begin
            check_output("frame_unexpected", 64'd1, 64'd0);
          end else begin
            f = frame_q.pop_front();
            check_output("frame_len", 64'(cap_cnt), 64'(f.len));
            check_output("frame_bits", cap, f.bits);
          end
          if (cap_cnt == 64 && cap[63:56] == 8'h02)
            for (int k = 0; k < 4; k++)
              psram_mem[wrap_addr(cap[54:32], k)] = cap[31-8*k -: 8];
        end
      end
    end

    // Pin timing: half periods of exactly DIV cycles, MOSI only moves with SCLK falling.
    logic prev_cen  = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    int   run       = 0;
    always @(negedge clk) begin
      if (cen === 1'b0) begin
        if (prev_cen !== 1'b0) begin
          check_output("frame_start_sclk", 64'(sclk), 64'd0);
          run = 1;
        end else if (sclk === prev_sclk) begin
          run++;
        end else begin
          check_output("sclk_half_period", 64'(run), 64'(DIV));
          run = 1;
        end
        if (prev_cen === 1'b0 && sio_o[0] !== prev_mosi)
          check_output("mosi_edge", 64'({prev_sclk, sclk}), 64'(2'b10));
      end
      prev_cen  = cen;
      prev_sclk = sclk;
      prev_mosi = sio_o[0];
    end

    always @(negedge clk) begin : rsp_monitor
      rsp_t r;
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check_output("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check_output("rsp_cycle", 64'(cyc), 64'(r.cycle));
          if (r.is_read) begin
            check_output("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
            last_read = r.data;
          end else begin
            check_output("rdata_hold", 64'(rsp_rdata), 64'(last_read));
          end
        end
      end
    end

    task automatic run_len(input logic level, output int n);
      n = 0;
      while (cen === level && n < 5000) begin
        n++;
        @(negedge clk);
      end
    endtask

    task automatic check_init();
      int n;
      run_len(1'b1, n);
      check_output("init_wait_len", 64'(n), 64'(INIT_CYCLES));
      run_len(1'b0, n);
      check_output("rsten_len", 64'(n), 64'(16 * DIV));
      run_len(1'b1, n);
      check_output("init_gap_len", 64'(n), 64'(CE_GAP));
      run_len(1'b0, n);
      check_output("rst_len", 64'(n), 64'(16 * DIV));
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check_output("init_done_delay", 64'(n), 64'(CE_GAP));
      check_output("ready_after_init", 64'(req_ready), 64'd1);
    endtask

    // Called on a negedge; reset takes effect at the following posedge.
    task automatic apply_reset();
      frame_t f;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_q.delete();
      frame_q.delete();
      last_read = '0;
      f.len = 8; f.bits = 64'h66; frame_q.push_back(f);
      f.len = 8; f.bits = 64'h99; frame_q.push_back(f);
      @(negedge clk);
      check_output("rst_cen", 64'(cen), 64'd1);
      check_output("rst_sclk", 64'(sclk), 64'd0);
      check_output("rst_ready", 64'(req_ready), 64'd0);
      check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_output("rst_rdata", 64'(rsp_rdata), 64'd0);
      check_output("rst_init_done", 64'(init_done), 64'd0);
      check_output("rst_sio_oe", 64'(sio_oe), 64'(4'b1101));
      check_output("rst_sio_o", 64'(sio_o), 64'(4'b1100));
      @(negedge clk);
      rst_n = 1'b1;
      check_init();
    endtask

    task automatic apply_stimulus(input logic we, input logic [22:0] addr,
                                  input logic [31:0] wdata, input bit keep_valid,
                                  input bit chained, input bit will_abort);
      int          k;
      int          waited;
      rsp_t        r;
      frame_t      f;
      logic [31:0] exp;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      waited    = 0;
      while (req_ready !== 1'b1 && waited < 3000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 3000) begin
        check_output("ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        return;
      end
      k = cyc;
      if (chained) check_output("b2b_accept_cycle", 64'(k), 64'(last_end + CE_GAP));
      exp = '0;
      if (we) begin
        f.bits = {8'h02, 1'b0, addr, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
        if (!will_abort)
          for (int b = 0; b < 4; b++) ref_mem[wrap_addr(addr, b)] = wdata[8*b +: 8];
      end else begin
        f.bits = {8'h03, 1'b0, addr, 32'h0};
        for (int b = 0; b < 4; b++) exp[8*b +: 8] = ref_byte(wrap_addr(addr, b));
      end
      f.len = 64;
      frame_q.push_back(f);
      r.is_read = !we;
      r.data    = exp;
      r.cycle   = k + 1 + 128 * DIV;
      rsp_q.push_back(r);
      last_end = r.cycle;
      @(negedge clk);
      if (!keep_valid) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 23'($urandom);
        req_wdata = $urandom;
      end
      check_output("ce_fall", 64'(cen), 64'd0);
      check_output("ready_drop", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || req_ready !== 1'b1) && n < 5000) begin
        n++;
        @(negedge clk);
      end
      if (n >= 5000) check_output("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
      bit prev_keep;
      apply_reset();

      apply_stimulus(1'b1, 23'h000010, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b0);
      wait_idle();
      apply_stimulus(1'b0, 23'h000010, 32'h0, 1'b0, 1'b0, 1'b0);
      wait_idle();

      // Valid held high across two requests, the second one crossing a page end.
      apply_stimulus(1'b1, 23'h0003FE, 32'h11223344, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 23'h0003FE, 32'h0, 1'b0, 1'b1, 1'b0);
      wait_idle();

      prev_keep = 1'b0;
      for (int i = 0; i < N_RANDOM; i++) begin
        logic        we;
        logic [22:0] a;
        bit          keep;
        we   = 1'($urandom_range(0, 1));
        a    = ($urandom_range(0, 3) == 0) ? 23'(32'h3FC + $urandom_range(0, 3))
                                           : 23'($urandom_range(0, 24));
        keep = (i != N_RANDOM - 1) && ($urandom_range(0, 2) == 0);
        apply_stimulus(we, a, $urandom, keep, prev_keep, 1'b0);
        if (!keep) repeat ($urandom_range(0, 4)) @(negedge clk);
        prev_keep = keep;
      end
      wait_idle();

      // Reset during bit 30 of a write: frame dropped, init sequence reruns.
      apply_stimulus(1'b1, 23'h000010, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
      repeat (2 * DIV * 30) @(negedge clk);
      apply_reset();
      apply_stimulus(1'b0, 23'h000010, 32'h0, 1'b0, 1'b0, 1'b0);
      wait_idle();

      check_output("leftover_rsp", 64'(rsp_q.size()), 64'd0);
      check_output("leftover_frames", 64'(frame_q.size()), 64'd0);
      lanes_done++;
    end
  end

  initial begin
    fork
      wait (lanes_done == 2);
      #600000;
    join_any
    if (lanes_done != 2) check_output("global_timeout", 64'(lanes_done), 64'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
